instruction_prefetch: RTL and testbench

Parametrised successor to the single-entry fetch stage. Streams sequential instruction words from Wishbone into a FIFO_DEPTH-entry queue, ahead of decode consumption. Decode pulls {pc, instruction} pairs through a valid/ready handshake. Branch redirects flush the queue and discard any in-flight bus response. Sits between the Wishbone instruction bus and decode.

---
 rtl/prefetch_pkg.sv | 18 +
 rtl/wishbone_if.sv | 22 ++
 rtl/fetch_fifo.sv | 72 +++++++
 rtl/instruction_prefetch.sv | 146 ++++++++++++++
 tb/tb_instruction_prefetch.sv | 337 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/prefetch_pkg.sv
// Shared types for the instruction prefetch stage: FSM states and queue entry layout.
// No logic here; imported by the prefetcher and its queue.
package prefetch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/wishbone_if.sv
// Classic Wishbone bus bundle; data_in is master write data, data_out is slave read data.
// Master drives request fields, slave returns data_out/ack.
interface wishbone_if;
    logic        strobe;
    logic        cycle;
    logic [3:0]  select;
    logic [31:0] address;
    logic        write_enable;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic        ack;

    modport master (
        output strobe, cycle, select, address, write_enable, data_in,
        input  data_out, ack
    );

    modport slave (
        input  strobe, cycle, select, address, write_enable, data_in,
        output data_out, ack
    );
endinterface

// File: rtl/fetch_fifo.sv
// Synchronous queue of fetch entries with a registered head; flush beats push and pop.
// Latency: a push into an empty queue is visible at the head the next cycle.
// Backpressure: push is dropped when full unless a pop frees a slot in the same cycle.
module fetch_fifo
    import prefetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     push,
    input  fetch_entry_t             push_entry,
    input  logic                     pop,
    output logic [$clog2(DEPTH):0]   count,
    output fetch_entry_t             head
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    fetch_entry_t   mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic           do_push;
    logic           do_pop;
    fetch_entry_t   next_head;

    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != CW'(DEPTH)) || do_pop);

    // The head register mirrors whatever entry sits at rd_ptr after this edge.
    always_comb begin
        next_head = head;
        if (do_pop) begin
            if (count > CW'(1))
                next_head = mem[rd_ptr + AW'(1)];
            else if (do_push)
                next_head = push_entry;
            else
                next_head = '0;
        end else if ((count == '0) && do_push) begin
            next_head = push_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush)
            mem[wr_ptr] <= push_entry;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            head   <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            head   <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
            head  <= next_head;
        end
    end

endmodule

// File: rtl/instruction_prefetch.sv
// Sequential Wishbone instruction prefetcher feeding decode through a FIFO_DEPTH queue.
// Latency: ack-after-strobe slave gives first valid 2 cycles after strobe; then 1 word/cycle.
// Backpressure: i_ready low fills the queue, then no request issues. PREFETCH_PERF_EN adds counters.
module instruction_prefetch
    import prefetch_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int          FIFO_DEPTH   = 4,
    parameter logic [31:0] ADDR_STRIDE  = 32'd4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_branch_enable,
    input  logic [31:0] i_branch_address,
    input  logic        i_ready,
    wishbone_if.master  wishbone_bus,
    output logic [31:0] o_instruction,
    output logic [31:0] o_pc,
    output logic        o_instruction_valid
`ifdef PREFETCH_PERF_EN
    ,
    output logic [31:0] o_fetch_count,
    output logic [31:0] o_flush_count
`endif
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    state_t         state;
    logic [31:0]    fetch_pc;
    logic [31:0]    addr_q;
    logic           cyc_q;
    logic           stb_q;
    logic [CW-1:0]  count;
    logic [CW-1:0]  count_after;
    logic           push;
    logic           pop;
    logic [31:0]    target;
    logic [31:0]    next_pc;
    fetch_entry_t   push_entry;
    fetch_entry_t   head;

    assign target      = i_branch_address & 32'hFFFF_FFFC;
    assign next_pc     = fetch_pc + ADDR_STRIDE;
    assign push        = (state == REQ) && wishbone_bus.ack && !i_branch_enable;
    assign pop         = o_instruction_valid && i_ready && !i_branch_enable;
    assign count_after = count + CW'(push) - CW'(pop);
    assign push_entry  = '{pc: addr_q, instr: wishbone_bus.data_out};

    assign wishbone_bus.cycle        = cyc_q;
    assign wishbone_bus.strobe       = stb_q;
    assign wishbone_bus.address      = addr_q;
    assign wishbone_bus.select       = 4'b1111;
    assign wishbone_bus.write_enable = 1'b0;
    assign wishbone_bus.data_in      = 32'h0;

    fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .flush      (i_branch_enable),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .count      (count),
        .head       (head)
    );

    assign o_instruction       = head.instr;
    assign o_pc                = head.pc;
    assign o_instruction_valid = (count != '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            fetch_pc <= RESET_VECTOR;
            addr_q   <= RESET_VECTOR;
            cyc_q    <= 1'b0;
            stb_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_branch_enable) begin
                        fetch_pc <= target;
                    end else if (count < CW'(FIFO_DEPTH)) begin
                        cyc_q  <= 1'b1;
                        stb_q  <= 1'b1;
                        addr_q <= fetch_pc;
                        state  <= REQ;
                    end
                end
                REQ: begin
                    if (i_branch_enable) begin
                        fetch_pc <= target;
                        if (wishbone_bus.ack) begin
                            cyc_q <= 1'b0;
                            stb_q <= 1'b0;
                            state <= IDLE;
                        end else begin
                            state <= DRAIN;
                        end
                    end else if (wishbone_bus.ack) begin
                        fetch_pc <= next_pc;
                        if (count_after < CW'(FIFO_DEPTH)) begin
                            addr_q <= next_pc;
                        end else begin
                            cyc_q <= 1'b0;
                            stb_q <= 1'b0;
                            state <= IDLE;
                        end
                    end
                end
                DRAIN: begin
                    // The stale response still has to complete on the bus before we re-issue.
                    if (i_branch_enable)
                        fetch_pc <= target;
                    if (wishbone_bus.ack) begin
                        cyc_q <= 1'b0;
                        stb_q <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef PREFETCH_PERF_EN
    logic [CW-1:0] flushed;
    logic          discard;

    assign flushed = i_branch_enable ? count : '0;
    assign discard = wishbone_bus.ack &&
                     (((state == REQ) && i_branch_enable) || (state == DRAIN));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            o_fetch_count <= 32'h0;
            o_flush_count <= 32'h0;
        end else begin
            if (push)
                o_fetch_count <= o_fetch_count + 32'd1;
            o_flush_count <= o_flush_count + 32'(flushed) + 32'(discard);
        end
    end
`endif

endmodule

// File: tb/tb_instruction_prefetch.sv
// Bench for instruction_prefetch: latency-programmable Wishbone slave, queue-level reference
// model checked every cycle, a branch vector table and directed corner-case sequences.
module tb_instruction_prefetch;
    import prefetch_pkg::*;

    localparam int          DEPTH = 4;
    localparam logic [31:0] RV    = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        i_branch_enable = 1'b0;
    logic [31:0] i_branch_address = 32'h0;
    logic        i_ready = 1'b0;
    logic [31:0] o_instruction;
    logic [31:0] o_pc;
    logic        o_instruction_valid;
`ifdef PREFETCH_PERF_EN
    logic [31:0] fetch_count;
    logic [31:0] flush_count;
`endif

    wishbone_if wb();

    instruction_prefetch #(.RESET_VECTOR(RV), .FIFO_DEPTH(DEPTH), .ADDR_STRIDE(32'd4)) dut (
        .clk                 (clk),
        .reset               (reset),
        .i_branch_enable     (i_branch_enable),
        .i_branch_address    (i_branch_address),
        .i_ready             (i_ready),
        .wishbone_bus        (wb),
        .o_instruction       (o_instruction),
        .o_pc                (o_pc),
        .o_instruction_valid (o_instruction_valid)
`ifdef PREFETCH_PERF_EN
        ,
        .o_fetch_count       (fetch_count),
        .o_flush_count       (flush_count)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return NOP_INSTR ^ {a[15:0], a[31:16]};
    endfunction

    // Slave: acks once the request has been held for lat cycles (lat=0 acks combinationally).
    int fixed_lat = 0;
    bit rand_lat = 1'b0;
    int rlat = 0;
    int wcnt = 0;
    int ack_count = 0;
    int eff_lat;
    assign eff_lat     = rand_lat ? rlat : fixed_lat;
    assign wb.ack      = wb.cycle && wb.strobe && (wcnt >= eff_lat);
    assign wb.data_out = mem_word(wb.address);

    always @(posedge clk) begin
        if (wb.ack) begin
            wcnt      <= 0;
            ack_count <= ack_count + 1;
            rlat      <= int'($urandom_range(0, 3));
        end else if (wb.cycle && wb.strobe) begin
            wcnt <= wcnt + 1;
        end else begin
            wcnt <= 0;
        end
    end

    // Reference: decode must see a contiguous pc stream restarting at each redirect target.
    logic [31:0] mq[$];
    logic [31:0] mfetch = RV;
    bit          mdrain = 1'b0;
    logic [31:0] m_push = 0;
    logic [31:0] m_disc = 0;

    always @(negedge clk) begin
        if (!reset) begin
            mq.delete();
            mfetch = RV;
            mdrain = 1'b0;
            m_push = 0;
            m_disc = 0;
        end else begin
            chk("m_valid", o_instruction_valid, mq.size() != 0);
            if (mq.size() != 0) begin
                chk("m_pc", o_pc, mq[0]);
                chk("m_instr", o_instruction, mem_word(mq[0]));
            end
            chk("m_cyc_stb", wb.cycle, wb.strobe);
            if (wb.strobe && !mdrain) begin
                chk("m_addr", wb.address, mfetch);
                chk("m_room", mq.size() < DEPTH, 1);
            end
            if (i_branch_enable) begin
                m_disc = m_disc + mq.size() + (wb.ack ? 1 : 0);
                mq.delete();
                mdrain = wb.strobe && !wb.ack;
                mfetch = i_branch_address & 32'hFFFF_FFFC;
            end else begin
                if (mq.size() != 0 && i_ready)
                    void'(mq.pop_front());
                if (wb.ack) begin
                    if (mdrain) begin
                        mdrain = 1'b0;
                        m_disc = m_disc + 1;
                    end else begin
                        mq.push_back(mfetch);
                        mfetch = mfetch + 32'd4;
                        m_push = m_push + 1;
                    end
                end
            end
        end
    end

    logic [31:0] pop_pc [8];
    logic [31:0] pop_in [8];
    int          pop_cyc [8];

    task automatic collect_pops(input int n);
        int got = 0;
        int c = 0;
        while (got < n && c < 100) begin
            @(negedge clk);
            if (o_instruction_valid && i_ready) begin
                pop_pc[got]  = o_pc;
                pop_in[got]  = o_instruction;
                pop_cyc[got] = c;
                got++;
            end
            c++;
        end
        if (got < n)
            chk("pop_timeout", got, n);
    endtask

    task automatic wait_strobe(input string nm, output logic [31:0] a);
        a = 32'hDEAD_BEEF;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (wb.strobe) begin
                a = wb.address;
                return;
            end
        end
        chk({nm, "_timeout"}, 0, 1);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b0;
        i_branch_enable = 1'b0;
        i_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
    endtask

    typedef struct {
        logic [31:0] target;
        int          lat;
        logic [31:0] pc0;
        logic [31:0] pc1;
        logic [31:0] pc2;
    } vec_t;

    vec_t        vec [4];
    logic [31:0] a;
    int          s_cyc;
    int          v_cyc;
    int          base;
    bit          hit;

    initial begin
        vec[0] = '{32'h0000_0202, 0, 32'h0000_0200, 32'h0000_0204, 32'h0000_0208};
        vec[1] = '{32'hFFFF_FFF8, 0, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
        vec[2] = '{32'h0000_0100, 2, 32'h0000_0100, 32'h0000_0104, 32'h0000_0108};
        vec[3] = '{32'h8000_0003, 1, 32'h8000_0000, 32'h8000_0004, 32'h8000_0008};

        // Reset values, sampled before the first post-reset edge.
        fixed_lat = 1;
        do_reset();
        @(negedge clk);
        chk("rst_valid", o_instruction_valid, 0);
        chk("rst_instr", o_instruction, 32'h0);
        chk("rst_pc", o_pc, 32'h0);
        chk("rst_stb", wb.strobe, 0);
        chk("rst_cyc", wb.cycle, 0);
        chk("rst_sel", wb.select, 4'b1111);
        chk("rst_we", wb.write_enable, 0);
        chk("rst_din", wb.data_in, 32'h0);
        chk("rst_addr", wb.address, RV);

        // Ack-after-strobe slave: first valid two cycles after strobe.
        i_ready = 1'b1;
        s_cyc = -1;
        v_cyc = -1;
        for (int c = 0; c < 20 && v_cyc < 0; c++) begin
            if (wb.strobe && s_cyc < 0) s_cyc = c;
            if (o_instruction_valid) v_cyc = c;
            if (v_cyc < 0) @(negedge clk);
        end
        chk("first_latency", v_cyc - s_cyc, 2);

        // Zero-wait slave: 0x0, 0x4, 0x8 on consecutive cycles.
        fixed_lat = 0;
        do_reset();
        i_ready = 1'b1;
        collect_pops(3);
        chk("seq_pc0", pop_pc[0], 32'h0);
        chk("seq_pc1", pop_pc[1], 32'h4);
        chk("seq_pc2", pop_pc[2], 32'h8);
        chk("seq_in2", pop_in[2], mem_word(32'h8));
        chk("seq_gap01", pop_cyc[1] - pop_cyc[0], 1);
        chk("seq_gap12", pop_cyc[2] - pop_cyc[1], 1);

        // Decode stalled: exactly DEPTH acks, then the bus goes quiet.
        do_reset();
        base = ack_count;
        repeat (20) @(negedge clk);
        chk("full_acks", ack_count - base, DEPTH);
        chk("full_stb", wb.strobe, 0);
        chk("full_head_pc", o_pc, 32'h0);
        chk("full_head_in", o_instruction, mem_word(32'h0));
        @(posedge clk); #1 i_ready = 1'b1;
        wait_strobe("resume", a);
        chk("resume_addr", a, 32'h10);

        // Branch vector table, applied from whatever state the stream is in.
        for (int i = 0; i < 4; i++) begin
            fixed_lat = vec[i].lat;
            @(posedge clk); #1;
            i_ready = 1'b1;
            i_branch_enable = 1'b1;
            i_branch_address = vec[i].target;
            @(posedge clk); #1 i_branch_enable = 1'b0;
            collect_pops(3);
            chk($sformatf("vec%0d_pc0", i), pop_pc[0], vec[i].pc0);
            chk($sformatf("vec%0d_pc1", i), pop_pc[1], vec[i].pc1);
            chk($sformatf("vec%0d_pc2", i), pop_pc[2], vec[i].pc2);
            chk($sformatf("vec%0d_in2", i), pop_in[2], mem_word(vec[i].pc2));
        end

        // Branch while a slow request is outstanding: the late response must be dropped.
        fixed_lat = 3;
        do_reset();
        wait_strobe("drain_req", a);
        @(posedge clk); #1;
        i_branch_enable = 1'b1;
        i_branch_address = 32'h0000_0100;
        @(negedge clk);
        chk("drain_premise", wb.ack, 0);
        @(posedge clk); #1 i_branch_enable = 1'b0;
        @(negedge clk);
        chk("drain_hold", wb.cycle && (wb.address == 32'h0), 1);
        hit = 1'b0;
        for (int n = 0; n < 30 && !hit; n++) begin
            @(negedge clk);
            if (wb.strobe && wb.address != 32'h0) hit = 1'b1;
        end
        chk("drain_next_addr", wb.address, 32'h100);
        chk("drain_no_stale", o_instruction_valid, 0);
        @(posedge clk); #1 i_ready = 1'b1;
        collect_pops(1);
        chk("drain_first_pc", pop_pc[0], 32'h100);

        // Branch landing on the same edge as an ack and a pop with the queue nearly full.
        fixed_lat = 2;
        do_reset();
        base = ack_count;
        hit = 1'b0;
        for (int n = 0; n < 60 && !hit; n++) begin
            @(posedge clk); #1;
            if (wb.ack && (ack_count - base) == DEPTH - 1) hit = 1'b1;
        end
        chk("coinc_premise", hit, 1);
        i_branch_enable = 1'b1;
        i_branch_address = 32'h0000_0202;
        i_ready = 1'b1;
        @(posedge clk); #1;
        i_branch_enable = 1'b0;
        i_ready = 1'b0;
        @(negedge clk);
        chk("coinc_empty", o_instruction_valid, 0);
        wait_strobe("coinc_req", a);
        chk("coinc_addr", a, 32'h200);

        // Reset in the middle of a request.
        fixed_lat = 3;
        do_reset();
        wait_strobe("mid_req", a);
        @(posedge clk); #3 reset = 1'b0;
        #1;
        chk("arst_cyc", wb.cycle, 0);
        chk("arst_stb", wb.strobe, 0);
        chk("arst_valid", o_instruction_valid, 0);
        @(posedge clk); #1 reset = 1'b1;
`ifdef PREFETCH_PERF_EN
        chk("arst_fetch_cnt", fetch_count, 32'h0);
        chk("arst_flush_cnt", flush_count, 32'h0);
`endif
        wait_strobe("post_rst", a);
        chk("post_rst_addr", a, RV);

        // Randomized traffic; the reference model checks every cycle.
        rand_lat = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            @(posedge clk); #1;
            i_ready = ($urandom_range(0, 3) != 0);
            i_branch_enable = ($urandom_range(0, 24) == 0);
            i_branch_address = ($urandom_range(0, 1) == 1) ? $urandom
                                                          : (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)));
        end
        @(posedge clk); #1 i_branch_enable = 1'b0;
        @(posedge clk); #2;
`ifdef PREFETCH_PERF_EN
        chk("perf_fetch", fetch_count, m_push);
        chk("perf_flush", flush_count, m_disc);
`endif
        chk("rand_pushes_seen", m_push > 100, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
